bsg_link_to_manycore_packet_deserializer: RTL

- Receive-side counterpart of the manycore-to-bsg_link serializer. Accepts a stream of narrow bsg_link-width flits over a ready-and handshake and reassembles one full-width manycore packet, fwd or rev, per num_flits_lp flits.
- Presents the packet on a ready-and output toward the manycore link.
- Sits in the bsg_link clock domain after the link receiver and before the async FIFO into the manycore domain. One instance per net.

---
 rtl/bsg_link_to_manycore_packet_deserializer.sv | 89 ++++++++
 1 files changed

// File: rtl/bsg_link_to_manycore_packet_deserializer.sv
// ============================================================================
// bsg_link_to_manycore_packet_deserializer
//   Reassembles narrow bsg_link flits (LSB flit first) into one manycore packet.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_link_to_manycore_packet_deserializer #(
  parameter int packet_width_p   = 70,
  parameter int bsg_link_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        flit_v_i,
  input  logic [bsg_link_width_p-1:0] flit_data_i,
  output logic                        flit_ready_and_o,

  output logic                        packet_v_o,
  output logic [packet_width_p-1:0]   packet_data_o,
  input  logic                        packet_ready_and_i
);

  localparam int num_flits_lp = (packet_width_p + bsg_link_width_p - 1) / bsg_link_width_p;
  localparam int cnt_width_lp = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(num_flits_lp - 1);

  logic [cnt_width_lp-1:0]   cnt_r;
  logic [packet_width_p-1:0] full_packet;
  logic                      is_last;
  logic                      flit_accept;
  logic                      packet_v_r;
  logic [packet_width_p-1:0] packet_data_r;

  assign is_last          = (cnt_r == last_cnt_lp);
  // Only the last flit needs room in the output register; earlier flits overlap a stalled packet.
  assign flit_ready_and_o = ~reset_i & (~is_last | ~packet_v_r | packet_ready_and_i);
  assign flit_accept      = flit_v_i & flit_ready_and_o;

  generate
    if (num_flits_lp > 1) begin : g_multi
      logic [(num_flits_lp-1)*bsg_link_width_p-1:0] asm_r;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          cnt_r <= '0;
        end else if (flit_accept) begin
          cnt_r <= is_last ? '0 : cnt_r + cnt_width_lp'(1);
        end
      end

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          asm_r <= '0;
        end else begin
          for (int k = 0; k < num_flits_lp-1; k++) begin
            if (flit_accept && (cnt_r == cnt_width_lp'(k))) begin
              asm_r[k*bsg_link_width_p +: bsg_link_width_p] <= flit_data_i;
            end
          end
        end
      end

      // Padding bits of the last flit fall off the top here.
      assign full_packet = packet_width_p'({flit_data_i, asm_r});
    end else begin : g_single
      assign cnt_r       = '0;
      assign full_packet = packet_width_p'(flit_data_i);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      packet_v_r    <= 1'b0;
      packet_data_r <= '0;
    end else if (flit_accept && is_last) begin
      packet_v_r    <= 1'b1;
      packet_data_r <= full_packet;
    end else if (packet_ready_and_i) begin
      packet_v_r    <= 1'b0;
    end
  end

  assign packet_v_o    = packet_v_r;
  assign packet_data_o = packet_data_r;

endmodule

`default_nettype wire
